// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-port AXI4 word RAM slave, one transaction at a time
module axi_ram_slave #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_OFFSET_WIDTH   = 28,
   parameter int C_ID_WIDTH       = 1,
   parameter int MEM_WORDS        = 2048
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [C_ID_WIDTH-1:0]       AWID,
   input  logic [C_OFFSET_WIDTH-1:0]   AWADDR,
   input  logic [7:0]                  AWLEN,
   input  logic [1:0]                  AWBURST,
   input  logic                        AWVALID,
   output logic                        AWREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0] WDATA,
   input  logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB,
   input  logic                        WLAST,
   input  logic                        WVALID,
   output logic                        WREADY,
   output logic [C_ID_WIDTH-1:0]       BID,
   output logic [1:0]                  BRESP,
   output logic                        BVALID,
   input  logic                        BREADY,
   input  logic [C_ID_WIDTH-1:0]       ARID,
   input  logic [C_OFFSET_WIDTH-1:0]   ARADDR,
   input  logic [7:0]                  ARLEN,
   input  logic [1:0]                  ARBURST,
   input  logic                        ARVALID,
   output logic                        ARREADY,
   output logic [C_ID_WIDTH-1:0]       RID,
   output logic [C_AXI_DATA_WIDTH-1:0] RDATA,
   output logic [1:0]                  RRESP,
   output logic                        RLAST,
   output logic                        RVALID,
   input  logic                        RREADY
);
   localparam int DW = C_AXI_DATA_WIDTH;
   localparam int AW = $clog2(MEM_WORDS);
   typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;
   state_t state_q, state_d;
   logic [C_ID_WIDTH-1:0] id_q, id_d;
   logic [AW-1:0] idx_q, idx_d, idx_nxt, rd_idx;
   logic [7:0] len_q, len_d, cnt_q, cnt_d;
   logic fixed_q, fixed_d, err_q, err_d, flag_q, flag_d;
   logic rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [1:0] bresp_q, bresp_d;
   logic grant_r, grant_w, rd_en, we, w_final;
   logic [DW-1:0] mem [MEM_WORDS];
   logic [DW-1:0] ram_q;
   logic unused_addr_bits;
   assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};
   assign ARREADY = grant_r;
   assign AWREADY = grant_w;
   assign RVALID  = rvalid_q;
   assign RLAST   = rlast_q;
   assign RID     = id_q;
   assign RDATA   = (rvalid_q && !err_q) ? ram_q : '0;
   assign RRESP   = (rvalid_q && err_q) ? 2'b10 : 2'b00;
   assign WREADY  = state_q == WR;
   assign BVALID  = state_q == WRESP;
   assign BRESP   = BVALID ? bresp_q : 2'b00;
   assign BID     = id_q;
   // next-state, arbitration, burst address stepping and RAM strobes
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      idx_d    = idx_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      fixed_d  = fixed_q;
      err_d    = err_q;
      flag_d   = flag_q;
      rvalid_d = rvalid_q;
      rlast_d  = rlast_q;
      bresp_d  = bresp_q;
      grant_r  = 1'b0;
      grant_w  = 1'b0;
      rd_en    = 1'b0;
      rd_idx   = idx_q;
      we       = 1'b0;
      idx_nxt  = fixed_q ? idx_q : idx_q + AW'(1);
      w_final  = cnt_q == len_q;
      case (state_q)
         IDLE: begin
            grant_r = ARVALID && (!AWVALID || !flag_q);
            grant_w = AWVALID && (!ARVALID || flag_q);
            if (ARVALID && AWVALID) flag_d = !flag_q;
            if (grant_r) begin
               state_d  = RD;
               id_d     = ARID;
               idx_d    = ARADDR[AW+1:2];
               len_d    = ARLEN;
               fixed_d  = ARBURST == 2'b00;
               err_d    = |ARADDR[C_OFFSET_WIDTH-1:AW+2];
               cnt_d    = 8'd0;
               rd_en    = 1'b1;
               rd_idx   = ARADDR[AW+1:2];
               rvalid_d = 1'b1;
               rlast_d  = ARLEN == 8'd0;
            end else if (grant_w) begin
               state_d = WR;
               id_d    = AWID;
               idx_d   = AWADDR[AW+1:2];
               len_d   = AWLEN;
               fixed_d = AWBURST == 2'b00;
               err_d   = |AWADDR[C_OFFSET_WIDTH-1:AW+2];
               cnt_d   = 8'd0;
            end
         end
         RD: begin
            if (RREADY && rlast_q) begin
               state_d  = IDLE;
               rvalid_d = 1'b0;
               rlast_d  = 1'b0;
            end else if (RREADY) begin
               cnt_d   = cnt_q + 8'd1;
               idx_d   = idx_nxt;
               rd_en   = 1'b1;
               rd_idx  = idx_nxt;
               rlast_d = cnt_q + 8'd1 == len_q;
            end
         end
         WR: begin
            if (WVALID) begin
               we    = !err_q;
               cnt_d = cnt_q + 8'd1;
               idx_d = idx_nxt;
               if (w_final || WLAST) begin
                  state_d = WRESP;
                  bresp_d = (err_q || (w_final != WLAST)) ? 2'b10 : 2'b00;
               end
            end
         end
         WRESP: if (BREADY) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // control registers; a reset aborts any burst in flight
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         id_q     <= '0;
         idx_q    <= '0;
         len_q    <= 8'd0;
         cnt_q    <= 8'd0;
         fixed_q  <= 1'b0;
         err_q    <= 1'b0;
         flag_q   <= 1'b0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         bresp_q  <= 2'b00;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         fixed_q  <= fixed_d;
         err_q    <= err_d;
         flag_q   <= flag_d;
         rvalid_q <= rvalid_d;
         rlast_q  <= rlast_d;
         bresp_q  <= bresp_d;
      end
   end
   // RAM array: byte-lane writes and registered read, contents survive reset
   always_ff @(posedge CLK) begin
      for (int i = 0; i < DW/8; i++)
         if (we && WSTRB[i]) mem[idx_q][8*i +: 8] <= WDATA[8*i +: 8];
      if (rd_en) ram_q <= mem[rd_idx];
   end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed self-checking bench for axi_ram_slave
module tb_axi_ram_slave;
   logic CLK, RST;
   logic [0:0] AWID, BID, ARID, RID;
   logic [27:0] AWADDR, ARADDR;
   logic [7:0] AWLEN, ARLEN;
   logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
   logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic [31:0] WDATA, RDATA;
   logic [3:0] WSTRB;
   int ncmp = 0, nfail = 0;
   logic [31:0] wd [16];
   logic [3:0] ws [16];
   logic [31:0] rd [16];
   logic [1:0] rr [16];
   logic rl [16];
   logic rv_first, rv_after;
   logic [0:0] rid_o, bid_o;
   logic [1:0] bresp_o;
   int nbeats, unstable;

   axi_ram_slave dut (
      .CLK(CLK), .RST(RST),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic set_ar(input logic [27:0] a, input logic [7:0] l, input logic [1:0] b, input logic id);
      ARADDR = a; ARLEN = l; ARBURST = b; ARID = id; ARVALID = 1'b1;
   endtask

   task automatic set_aw(input logic [27:0] a, input logic [7:0] l, input logic [1:0] b, input logic id);
      AWADDR = a; AWLEN = l; AWBURST = b; AWID = id; AWVALID = 1'b1;
   endtask

   task automatic wait_ar();
      int n = 0;
      #1;
      while (!ARREADY && n < 40) begin @(negedge CLK); #1; n++; end
      if (n >= 40) begin ncmp++; nfail++; $display("FAIL ar_timeout ARREADY=%b required 1", ARREADY); end
      @(negedge CLK);
      ARVALID = 1'b0;
   endtask

   task automatic wait_aw();
      int n = 0;
      #1;
      while (!AWREADY && n < 40) begin @(negedge CLK); #1; n++; end
      if (n >= 40) begin ncmp++; nfail++; $display("FAIL aw_timeout AWREADY=%b required 1", AWREADY); end
      @(negedge CLK);
      AWVALID = 1'b0;
   endtask

   task automatic r_phase(input logic [7:0] len, input bit stall);
      int cyc = 0;
      bit held = 0;
      logic [31:0] hd;
      logic [1:0] hr;
      logic hl;
      nbeats = 0; unstable = 0;
      #1;
      rv_first = RVALID;
      while (nbeats <= int'(len) && cyc < 100) begin
         RREADY = !stall || (cyc % 2 == 0);
         #1;
         if (RVALID) begin
            if (held && (RDATA !== hd || RRESP !== hr || RLAST !== hl)) unstable++;
            if (RREADY) begin
               rd[nbeats] = RDATA; rr[nbeats] = RRESP; rl[nbeats] = RLAST;
               if (nbeats == 0) rid_o = RID;
               nbeats++; held = 0;
            end else begin
               held = 1; hd = RDATA; hr = RRESP; hl = RLAST;
            end
         end
         @(negedge CLK);
         cyc++;
      end
      RREADY = 1'b0;
      if (cyc >= 100) begin ncmp++; nfail++; $display("FAIL r_timeout beats=%0d required %0d", nbeats, int'(len) + 1); end
      #1;
      rv_after = RVALID;
   endtask

   task automatic w_phase(input logic [7:0] len, input int lastbeat);
      int n;
      for (int i = 0; i <= int'(len) && i <= lastbeat; i++) begin
         WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == lastbeat); WVALID = 1'b1;
         #1;
         n = 0;
         while (!WREADY && n < 40) begin @(negedge CLK); #1; n++; end
         if (n >= 40) begin ncmp++; nfail++; $display("FAIL w_timeout WREADY=%b required 1", WREADY); end
         @(negedge CLK);
      end
      WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
      #1;
      n = 0;
      while (!BVALID && n < 40) begin @(negedge CLK); #1; n++; end
      if (n >= 40) begin ncmp++; nfail++; $display("FAIL b_timeout BVALID=%b required 1", BVALID); end
      bresp_o = BRESP; bid_o = BID;
      @(negedge CLK);
      BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [27:0] a, input logic [7:0] l, input logic [1:0] b, input logic id, input bit stall);
      @(negedge CLK);
      set_ar(a, l, b, id);
      wait_ar();
      r_phase(l, stall);
   endtask

   task automatic do_write(input logic [27:0] a, input logic [7:0] l, input logic [1:0] b, input logic id, input int lastbeat);
      @(negedge CLK);
      set_aw(a, l, b, id);
      wait_aw();
      w_phase(l, lastbeat);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      AWID = 0; AWADDR = 0; AWLEN = 0; AWBURST = 0; AWVALID = 0;
      WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
      ARID = 0; ARADDR = 0; ARLEN = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;
      repeat (3) @(negedge CLK);
      ncmp++;
      if ({ARREADY, AWREADY, WREADY, BVALID, RVALID, RLAST, RRESP, BRESP, RDATA, RID, BID} !== 45'd0) begin
         nfail++;
         $display("FAIL reset_outputs got %h required 0", {ARREADY, AWREADY, WREADY, BVALID, RVALID, RLAST, RRESP, BRESP, RDATA, RID, BID});
      end
      RST = 1'b0;
   endtask

   task automatic test_single_read();
      wd[0] = 32'h3E800093; wd[1] = 32'h7D008113; wd[2] = 32'h12345678;
      wd[3] = 32'hCAFEF00D; wd[4] = 32'h0; wd[5] = 32'h0;
      for (int i = 0; i < 6; i++) ws[i] = 4'hF;
      do_write(28'h0, 8'd5, 2'b01, 1'b0, 5);
      ncmp++; if (bresp_o !== 2'b00) begin nfail++; $display("FAIL preload_bresp got %b required 00", bresp_o); end
      ncmp++; if (RVALID !== 1'b0) begin nfail++; $display("FAIL idle_rvalid got %b required 0", RVALID); end
      do_read(28'h0, 8'd0, 2'b01, 1'b1, 0);
      ncmp++; if (rv_first !== 1'b1) begin nfail++; $display("FAIL single_rvalid_latency got %b required 1", rv_first); end
      ncmp++; if (rd[0] !== 32'h3E800093) begin nfail++; $display("FAIL single_rdata got %h required 3e800093", rd[0]); end
      ncmp++; if ({rl[0], rr[0]} !== 3'b100) begin nfail++; $display("FAIL single_rlast_rresp got %b required 100", {rl[0], rr[0]}); end
      ncmp++; if (rid_o !== 1'b1) begin nfail++; $display("FAIL single_rid got %b required 1", rid_o); end
      ncmp++; if (rv_after !== 1'b0) begin nfail++; $display("FAIL single_rvalid_after got %b required 0", rv_after); end
   endtask

   task automatic test_incr_stall();
      logic [31:0] exp [4];
      exp[0] = 32'h7D008113; exp[1] = 32'h12345678; exp[2] = 32'hCAFEF00D; exp[3] = 32'h0;
      do_read(28'h4, 8'd3, 2'b01, 1'b0, 1);
      for (int i = 0; i < 4; i++) begin
         ncmp++; if (rd[i] !== exp[i]) begin nfail++; $display("FAIL incr_rdata[%0d] got %h required %h", i, rd[i], exp[i]); end
         ncmp++; if ({rl[i], rr[i]} !== {i == 3, 2'b00}) begin nfail++; $display("FAIL incr_rlast_rresp[%0d] got %b required %b", i, {rl[i], rr[i]}, {i == 3, 2'b00}); end
      end
      ncmp++; if (unstable !== 0) begin nfail++; $display("FAIL incr_stall_stable got %0d changes required 0", unstable); end
   endtask

   task automatic test_strobe_write();
      wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101; wd[1] = 32'h11223344; ws[1] = 4'b1111;
      do_write(28'h10, 8'd1, 2'b01, 1'b1, 1);
      ncmp++; if ({bid_o, bresp_o} !== 3'b100) begin nfail++; $display("FAIL strobe_bid_bresp got %b required 100", {bid_o, bresp_o}); end
      do_read(28'h10, 8'd1, 2'b01, 1'b0, 0);
      ncmp++; if (rd[0] !== 32'h00BB00DD) begin nfail++; $display("FAIL strobe_word0 got %h required 00bb00dd", rd[0]); end
      ncmp++; if (rd[1] !== 32'h11223344) begin nfail++; $display("FAIL strobe_word1 got %h required 11223344", rd[1]); end
   endtask

   task automatic test_fixed_wrap();
      do_read(28'h4, 8'd2, 2'b00, 1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         ncmp++; if (rd[i] !== 32'h7D008113) begin nfail++; $display("FAIL fixed_rdata[%0d] got %h required 7d008113", i, rd[i]); end
      end
      ncmp++; if (rl[2] !== 1'b1) begin nfail++; $display("FAIL fixed_rlast got %b required 1", rl[2]); end
      wd[0] = 32'h0BADBEEF; ws[0] = 4'hF;
      do_write(28'h1FFC, 8'd0, 2'b01, 1'b0, 0);
      do_read(28'h1FFC, 8'd1, 2'b01, 1'b0, 0);
      ncmp++; if (rd[0] !== 32'h0BADBEEF) begin nfail++; $display("FAIL wrap_top got %h required 0badbeef", rd[0]); end
      ncmp++; if (rd[1] !== 32'h3E800093) begin nfail++; $display("FAIL wrap_bottom got %h required 3e800093", rd[1]); end
      ncmp++; if ({rr[0], rr[1]} !== 4'b0000) begin nfail++; $display("FAIL wrap_rresp got %b required 0000", {rr[0], rr[1]}); end
   endtask

   task automatic test_arbitration();
      @(negedge CLK);
      set_ar(28'h8, 8'd0, 2'b01, 1'b0);
      set_aw(28'h20, 8'd0, 2'b01, 1'b1);
      #1;
      ncmp++; if ({ARREADY, AWREADY} !== 2'b10) begin nfail++; $display("FAIL arb_first_grant got %b required 10", {ARREADY, AWREADY}); end
      wait_ar();
      r_phase(8'd0, 0);
      ncmp++; if (rd[0] !== 32'h12345678) begin nfail++; $display("FAIL arb_read1 got %h required 12345678", rd[0]); end
      wd[0] = 32'h55AA55AA; ws[0] = 4'hF;
      wait_aw();
      w_phase(8'd0, 0);
      ncmp++; if (bresp_o !== 2'b00) begin nfail++; $display("FAIL arb_write1_bresp got %b required 00", bresp_o); end
      set_ar(28'h20, 8'd0, 2'b01, 1'b1);
      set_aw(28'h24, 8'd0, 2'b01, 1'b0);
      #1;
      ncmp++; if ({ARREADY, AWREADY} !== 2'b01) begin nfail++; $display("FAIL arb_second_grant got %b required 01", {ARREADY, AWREADY}); end
      wd[0] = 32'h600DF00D;
      wait_aw();
      w_phase(8'd0, 0);
      ncmp++; if ({bid_o, bresp_o} !== 3'b000) begin nfail++; $display("FAIL arb_write2_bid_bresp got %b required 000", {bid_o, bresp_o}); end
      wait_ar();
      r_phase(8'd0, 0);
      ncmp++; if ({rid_o, rd[0]} !== {1'b1, 32'h55AA55AA}) begin nfail++; $display("FAIL arb_read2 got %h required 155aa55aa", {rid_o, rd[0]}); end
      do_read(28'h24, 8'd0, 2'b01, 1'b0, 0);
      ncmp++; if (rd[0] !== 32'h600DF00D) begin nfail++; $display("FAIL arb_write2_data got %h required 600df00d", rd[0]); end
   endtask

   task automatic test_out_of_range();
      do_read(28'h2000, 8'd1, 2'b01, 1'b0, 0);
      for (int i = 0; i < 2; i++) begin
         ncmp++; if ({rd[i], rr[i], rl[i]} !== {32'h0, 2'b10, i == 1}) begin nfail++; $display("FAIL oor_read[%0d] got %h/%b/%b required 0/10/%b", i, rd[i], rr[i], rl[i], i == 1); end
      end
      wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
      do_write(28'h2000, 8'd0, 2'b01, 1'b0, 0);
      ncmp++; if (bresp_o !== 2'b10) begin nfail++; $display("FAIL oor_bresp got %b required 10", bresp_o); end
      do_read(28'h0, 8'd0, 2'b01, 1'b0, 0);
      ncmp++; if (rd[0] !== 32'h3E800093) begin nfail++; $display("FAIL oor_ram_intact got %h required 3e800093", rd[0]); end
   endtask

   task automatic test_wlast_error();
      wd[0] = 32'hA1A1A1A1; wd[1] = 32'hA2A2A2A2; ws[0] = 4'hF; ws[1] = 4'hF;
      do_write(28'h18, 8'd2, 2'b01, 1'b0, 1);
      ncmp++; if (bresp_o !== 2'b10) begin nfail++; $display("FAIL wlast_early_bresp got %b required 10", bresp_o); end
      ncmp++; if (WREADY !== 1'b0) begin nfail++; $display("FAIL wlast_wready_after got %b required 0", WREADY); end
      do_read(28'h18, 8'd1, 2'b01, 1'b0, 0);
      ncmp++; if ({rd[0], rd[1]} !== {32'hA1A1A1A1, 32'hA2A2A2A2}) begin nfail++; $display("FAIL wlast_data got %h required a1a1a1a1a2a2a2a2", {rd[0], rd[1]}); end
   endtask

   task automatic test_reset_mid_burst();
      @(negedge CLK);
      set_ar(28'h0, 8'd7, 2'b01, 1'b0);
      wait_ar();
      RREADY = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      #1;
      ncmp++; if ({RVALID, RDATA} !== {1'b1, 32'h12345678}) begin nfail++; $display("FAIL rst_beat2 got %h required 112345678", {RVALID, RDATA}); end
      RST = 1'b1;
      #1;
      ncmp++; if ({RVALID, RLAST, RDATA} !== 34'd0) begin nfail++; $display("FAIL rst_abort got %h required 0", {RVALID, RLAST, RDATA}); end
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         ncmp++; if (RVALID !== 1'b0) begin nfail++; $display("FAIL rst_no_beats[%0d] got %b required 0", i, RVALID); end
         @(negedge CLK);
      end
      RREADY = 1'b0;
      do_read(28'h0, 8'd1, 2'b01, 1'b1, 0);
      ncmp++; if ({rd[0], rd[1]} !== {32'h3E800093, 32'h7D008113}) begin nfail++; $display("FAIL rst_ram_intact got %h required 3e8000937d008113", {rd[0], rd[1]}); end
      ncmp++; if ({rl[1], rr[1], rid_o} !== 4'b1001) begin nfail++; $display("FAIL rst_after_read got %b required 1001", {rl[1], rr[1], rid_o}); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_incr_stall();
      test_strobe_write();
      test_fixed_wrap();
      test_arbitration();
      test_out_of_range();
      test_wlast_error();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
